// File: rtl/mc_muldiv_unit.sv
// Iterative multiply/divide coprocessor holding the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module mc_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 is_div_reg;
  logic [WIDTH-1:0]     acc_reg, mq_reg, opd_reg, a_reg;
  logic [WIDTH-1:0]     hi_reg, lo_reg;
  logic                 neg_q_reg, neg_r_reg, dz_pend_reg;
  logic                 busy_reg, done_reg, div_zero_reg;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]     acc_next, mq_next;
  logic [2*WIDTH-1:0]   prod, prod_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Signed ops work on magnitudes; op[0]=0 marks the signed variants.
  always_comb begin
    a_neg = ~op[0] & a_i[WIDTH-1];
    b_neg = ~op[0] & b_i[WIDTH-1];
    abs_a = a_neg ? -a_i : a_i;
    abs_b = b_neg ? -b_i : b_i;
  end

  // mq holds the multiplier (shifted out from the bottom) or the dividend
  // (shifted out from the top, quotient bits shifted in behind it).
  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, opd_reg} : '0);
    div_shift = {acc_reg, mq_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_reg};
    acc_next  = mul_sum[WIDTH:1];
    mq_next   = {mul_sum[0], mq_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      if (!div_diff[WIDTH]) begin
        acc_next = div_diff[WIDTH-1:0];
        mq_next  = {mq_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = div_shift[WIDTH-1:0];
        mq_next  = {mq_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod     = {acc_reg, mq_reg};
    prod_fix = neg_q_reg ? -prod : prod;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      fix_lo = neg_q_reg ? -mq_reg : mq_reg;
      fix_hi = neg_r_reg ? -acc_reg : acc_reg;
      // Zero divisor: fixed pattern regardless of the iteration's output.
      if (dz_pend_reg) begin
        fix_lo = '1;
        fix_hi = a_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      acc_reg      <= '0;
      mq_reg       <= '0;
      opd_reg      <= '0;
      a_reg        <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dz_pend_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hi_we) hi_reg <= wdata_i;
          if (lo_we) lo_reg <= wdata_i;
          if (start) begin
            is_div_reg   <= op[1];
            a_reg        <= a_i;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            dz_pend_reg  <= op[1] && (b_i == '0);
            mq_reg       <= op[1] ? abs_a : abs_b;
            opd_reg      <= op[1] ? abs_b : abs_a;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            div_zero_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          mq_reg  <= mq_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) state_reg <= FIX;
        end
        FIX: begin
          hi_reg       <= fix_hi;
          lo_reg       <= fix_lo;
          div_zero_reg <= dz_pend_reg;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi_o     = hi_reg;
  assign lo_o     = lo_reg;

endmodule

// File: doc/mc_muldiv_unit.md
Name: mc_muldiv_unit

Overview:
- Iterative multiply/divide coprocessor for the multi-cycle MIPS core; implements MULT, MULTU, DIV, DIVU and owns the HI/LO registers.
- The controller issues an operation with a one-cycle start pulse and holds in a wait state while busy is high.
- MFHI/MFLO read hi_o/lo_o directly; MTHI/MTLO write through the hi_we/lo_we ports.
- Operand width is parametrised so the same unit serves narrower test datapaths.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; accepted only when busy=0
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a_i  input  WIDTH  rs operand (multiplicand / dividend)
b_i  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata_i  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO receive a result
div_zero  output  1  high with done when DIV/DIVU had b_i=0; holds until the next accepted start
hi_o  output  WIDTH  HI register
lo_o  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, any state, including mid-operation): state IDLE; hi_o=0, lo_o=0; busy=0, done=0, div_zero=0; counter=0. Any operation in flight is discarded.
- States and transitions: IDLE -> RUN -> FIX -> IDLE.
- IDLE: on start=1, latch op and |a_i|, |b_i| (absolute values for signed ops), latch the result sign bits, clear the partial accumulator, counter=0, go to RUN. busy rises the next cycle.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; exactly WIDTH cycles; counter increments each cycle and the state moves to FIX when counter reaches WIDTH-1.
- FIX: apply signed corrections:
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Write HI/LO, pulse done=1, drop busy=0 in the same cycle, return to IDLE.
- Latency: start sampled at edge N; done=1 and new HI/LO visible in the cycle after edge N+WIDTH+1.
- Results:
  - Multiply: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: the iteration still runs full length (fixed latency); result is LO = all ones, HI = a_i unchanged, div_zero=1.
- Signed overflow (-2^(WIDTH-1) / -1): LO = -2^(WIDTH-1), HI = 0, no flag.
- start while busy=1: ignored, no state change, no queuing.
- hi_we/lo_we while busy=0: update the register at the clock edge. While busy=1: ignored.
- hi_we/lo_we in the same cycle as an accepted start: the write takes effect, then the result overwrites it at completion.
- hi_we and lo_we together: both registers are written with wdata_i.
- Operands a_i/b_i may change after the start cycle without affecting the result.
- done is never high for two consecutive cycles.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> done at start+34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1 with done and held afterwards.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Start MULTU 5*6, pulse start again at cycle 10 and hi_we at cycle 12 -> both ignored; result hi=0, lo=30.
- Start DIVU 100/7, assert reset at cycle 15 -> next cycle busy=0, hi=lo=0, and no done pulse ever appears.
- Idle lo_we with wdata=0xA5A5A5A5 -> lo_o=0xA5A5A5A5 next cycle, hi_o unchanged.
